// File: rtl/robot_if.sv
// Sensor/command bundle between the maze map and the navigation controller.
// The passos step counter is present only when ROBOT_STEP_COUNTER_EN is defined.
interface robot_if;
    logic       habilita;
    logic       head;
    logic       left;
    logic       under;
    logic       barrier;
    logic       avancar;
    logic       girar;
    logic       remover;
    logic [2:0] estado;
    logic       fim;
    logic       preso;
`ifdef ROBOT_STEP_COUNTER_EN
    logic [15:0] passos;
`endif

    // Controller side: reads sensors, drives command pulses and status.
    modport master (
        input  habilita, head, left, under, barrier,
        output avancar, girar, remover, estado, fim, preso
`ifdef ROBOT_STEP_COUNTER_EN
        , output passos
`endif
    );

    // Map side: drives sensors, consumes commands and status.
    modport slave (
        output habilita, head, left, under, barrier,
        input  avancar, girar, remover, estado, fim, preso
`ifdef ROBOT_STEP_COUNTER_EN
        , input passos
`endif
    );
endinterface

// File: rtl/robot_controller.sv
// Left-hand wall-following navigation FSM for the maze robot.
// Decides once per PERIODO_PASSO cycles and emits one-cycle avancar/girar/remover pulses.
// Optional: ROBOT_STEP_COUNTER_EN adds the saturating passos advance counter.
module robot_controller #(
    parameter int unsigned PERIODO_PASSO = 25000000,
    parameter int unsigned MAX_GIROS_DIR = 4
) (
    input logic      Clock50,
    input logic      Reset,
    robot_if.master  robo
);

    localparam int unsigned GIROS_W = $clog2(MAX_GIROS_DIR + 1);

    typedef enum logic [2:0] {
        StInicio  = 3'd0,
        StSegue   = 3'd1,
        StPosGiro = 3'd2,
        StGiraDir = 3'd3,
        StRemove  = 3'd4,
        StFim     = 3'd5,
        StPreso   = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [24:0]          cnt_q, cnt_d;
    logic [1:0]           sub_q, sub_d;
    logic [GIROS_W-1:0]   giros_q, giros_d, giros_inc;
    logic                 avancar_q, avancar_d;
    logic                 girar_q, girar_d;
    logic                 remover_q, remover_d;
    logic                 tick;
    logic                 apply_segue;

    assign tick      = (cnt_q == 25'(PERIODO_PASSO - 1));
    assign cnt_d     = tick ? '0 : cnt_q + 25'd1;
    assign giros_inc = (giros_q == '1) ? giros_q : giros_q + GIROS_W'(1);

    // State, counters and registered command pulses.
    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            state_q   <= StInicio;
            cnt_q     <= '0;
            sub_q     <= '0;
            giros_q   <= '0;
            avancar_q <= 1'b0;
            girar_q   <= 1'b0;
            remover_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            giros_q   <= giros_d;
            avancar_q <= avancar_d;
            girar_q   <= girar_d;
            remover_q <= remover_d;
        end
    end

    // Next-state and next-command decision, evaluated only on tick.
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        giros_d     = giros_q;
        avancar_d   = 1'b0;
        girar_d     = 1'b0;
        remover_d   = 1'b0;
        apply_segue = 1'b0;
        if (tick) begin
            if (!robo.habilita) begin
                state_d = StInicio;
                sub_d   = '0;
                giros_d = '0;
            end else begin
                case (state_q)
                    StInicio: state_d = StSegue;
                    StSegue:  apply_segue = 1'b1;
                    StPosGiro: begin
                        if (robo.under) begin
                            state_d = StFim;
                        end else if (robo.barrier) begin
                            remover_d = 1'b1;
                            state_d   = StRemove;
                        end else if (!robo.head) begin
                            avancar_d = 1'b1;
                            giros_d   = '0;
                            state_d   = StSegue;
                        end else begin
                            // Never a second left turn in a row: go right instead.
                            girar_d = 1'b1;
                            sub_d   = 2'd2;
                            state_d = StGiraDir;
                        end
                    end
                    StGiraDir: begin
                        // A right turn is three left turns; sub_q counts what remains.
                        girar_d = 1'b1;
                        sub_d   = sub_q - 2'd1;
                        if (sub_q == 2'd1) begin
                            giros_d = giros_inc;
                            state_d = (giros_inc == GIROS_W'(MAX_GIROS_DIR)) ? StPreso : StSegue;
                        end
                    end
                    StRemove: begin
                        if (robo.barrier) begin
                            remover_d = 1'b1;
                        end else begin
                            apply_segue = 1'b1;
                        end
                    end
                    StFim:   state_d = StFim;
                    StPreso: state_d = StPreso;
                    default: state_d = StInicio;
                endcase
                if (apply_segue) begin
                    if (robo.under) begin
                        state_d = StFim;
                    end else if (robo.barrier) begin
                        remover_d = 1'b1;
                        state_d   = StRemove;
                    end else if (!robo.left) begin
                        girar_d = 1'b1;
                        state_d = StPosGiro;
                    end else if (!robo.head) begin
                        avancar_d = 1'b1;
                        giros_d   = '0;
                        state_d   = StSegue;
                    end else begin
                        girar_d = 1'b1;
                        sub_d   = 2'd2;
                        state_d = StGiraDir;
                    end
                end
            end
        end
    end

    // Outputs: registered pulses plus status levels decoded from the state.
    always_comb begin
        robo.avancar = avancar_q;
        robo.girar   = girar_q;
        robo.remover = remover_q;
        robo.estado  = state_q;
        robo.fim     = (state_q == StFim);
        robo.preso   = (state_q == StPreso);
    end

`ifdef ROBOT_STEP_COUNTER_EN
    logic [15:0] passos_q;

    // Saturating count of issued advances, cleared whenever the FSM returns to INICIO.
    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            passos_q <= '0;
        end else if (state_d == StInicio) begin
            passos_q <= '0;
        end else if (avancar_d && (passos_q != 16'hFFFF)) begin
            passos_q <= passos_q + 16'd1;
        end
    end

    assign robo.passos = passos_q;
`endif

endmodule

// File: tb/tb_robot_controller.sv
// Directed-vector bench for robot_controller with PERIODO_PASSO=4, MAX_GIROS_DIR=4.
module tb_robot_controller;

    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_AV   = 3'b100;
    localparam logic [2:0] CMD_GI   = 3'b010;
    localparam logic [2:0] CMD_RM   = 3'b001;

    logic Clock50;
    logic Reset;
    int   n_vec;
    int   n_err;
    logic [2:0] st_prev;
    int   exp_passos;

    robot_if bus ();

    robot_controller #(
        .PERIODO_PASSO (4),
        .MAX_GIROS_DIR (4)
    ) dut (
        .Clock50 (Clock50),
        .Reset   (Reset),
        .robo    (bus.master)
    );

    initial begin
        Clock50 = 1'b0;
        forever #5 Clock50 = ~Clock50;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] cmd_now();
        return {bus.avancar, bus.girar, bus.remover};
    endfunction

    // Runs one decision period; checks idle cycles and the result of the tick.
    task automatic tick(input logic [2:0] exp_cmd, input logic [2:0] exp_st);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock50);
            #1;
            if (i == 3) begin
                check_val("cmd", 16'(cmd_now()), 16'(exp_cmd));
                check_val("estado", 16'(bus.estado), 16'(exp_st));
                check_val("fim", 16'(bus.fim), 16'(exp_st == 3'd5));
                check_val("preso", 16'(bus.preso), 16'(exp_st == 3'd6));
`ifdef ROBOT_STEP_COUNTER_EN
                if (exp_st == 3'd0) exp_passos = 0;
                else if (exp_cmd == CMD_AV) exp_passos++;
                check_val("passos", bus.passos, 16'(exp_passos));
`endif
            end else begin
                check_val("cmd_idle", 16'(cmd_now()), 16'(CMD_NONE));
                check_val("estado_hold", 16'(bus.estado), 16'(st_prev));
            end
        end
        st_prev = exp_st;
    endtask

    task automatic check_reset_state();
        check_val("rst_cmd", 16'(cmd_now()), 16'(CMD_NONE));
        check_val("rst_estado", 16'(bus.estado), 16'd0);
        check_val("rst_fim", 16'(bus.fim), 16'd0);
        check_val("rst_preso", 16'(bus.preso), 16'd0);
`ifdef ROBOT_STEP_COUNTER_EN
        check_val("rst_passos", bus.passos, 16'd0);
`endif
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        st_prev     = 3'd0;
        exp_passos  = 0;
        Reset       = 1'b1;
        bus.habilita = 1'b0;
        bus.head    = 1'b0;
        bus.left    = 1'b0;
        bus.under   = 1'b0;
        bus.barrier = 1'b0;
        #12;
        check_reset_state();

        // Enable: INICIO -> SEGUE, then straight advances along a left wall.
        bus.habilita = 1'b1;
        bus.left     = 1'b1;
        bus.head     = 1'b0;
        @(negedge Clock50);
        Reset = 1'b0;
        tick(CMD_NONE, 3'd1);
        tick(CMD_AV, 3'd1);
        tick(CMD_AV, 3'd1);

        // Opening on the left: turn left, then advance from POS_GIRO.
        bus.left = 1'b0;
        tick(CMD_GI, 3'd2);
        bus.left = 1'b1;
        tick(CMD_AV, 3'd1);

        // Boxed in: four right turns (12 girar) then trapped.
        bus.head = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick(CMD_GI, 3'd3);
            tick(CMD_GI, 3'd3);
            tick(CMD_GI, (t == 3) ? 3'd6 : 3'd1);
        end
        tick(CMD_NONE, 3'd6);

        // habilita low clears PRESO; re-enable.
        bus.habilita = 1'b0;
        tick(CMD_NONE, 3'd0);
        bus.habilita = 1'b1;
        bus.head     = 1'b0;
        tick(CMD_NONE, 3'd1);

        // Trash ahead for six ticks, then the path clears.
        bus.barrier = 1'b1;
        for (int t = 0; t < 6; t++) tick(CMD_RM, 3'd4);
        bus.barrier = 1'b0;
        tick(CMD_AV, 3'd1);

        // Asynchronous reset while avancar is high.
        Reset = 1'b1;
        #1;
        check_reset_state();
        st_prev    = 3'd0;
        exp_passos = 0;
        @(negedge Clock50);
        Reset = 1'b0;
        tick(CMD_NONE, 3'd1);

        // Reach the black cell, then disable.
        tick(CMD_AV, 3'd1);
        bus.under = 1'b1;
        tick(CMD_NONE, 3'd5);
        tick(CMD_NONE, 3'd5);
        bus.habilita = 1'b0;
        tick(CMD_NONE, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
